// File: rtl/load_store_ctrl_if.sv
// rtl/load_store_ctrl_if.sv - request and data-memory bus bundle for load_store_ctrl
interface load_store_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        misalign_exc;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    // master: requester plus memory model; slave: the sequencer
    modport master (
        output start, op, addr, wdata, mem_dout,
        input  rdata, busy, done, misalign_exc, mem_addr, mem_wr, mem_din
    );

    modport slave (
        input  start, op, addr, wdata, mem_dout,
        output rdata, busy, done, misalign_exc, mem_addr, mem_wr, mem_din
    );
endinterface

// File: rtl/load_store_ctrl.sv
// rtl/load_store_ctrl.sv - multicycle load/store sequencer with sub-word read-modify-write
module load_store_ctrl #(
    parameter int unsigned MEM_LAT = 1
) (
    input logic               clk,
    input logic               reset,
    load_store_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        exc_q, exc_d;

    logic        misaligned;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        misaligned = 1'b0;
        case (bus.op)
            OP_LW, OP_SW:         misaligned = (bus.addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = bus.addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    // Extraction and merge work on the live memory word, which is valid
    // in the last WAIT cycle when these results are registered.
    always_comb begin
        sel_byte = 8'h00;
        case (off_q)
            2'd0:    sel_byte = bus.mem_dout[7:0];
            2'd1:    sel_byte = bus.mem_dout[15:8];
            2'd2:    sel_byte = bus.mem_dout[23:16];
            default: sel_byte = bus.mem_dout[31:24];
        endcase
        sel_half = off_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];

        load_val = bus.mem_dout;
        case (op_q)
            OP_LH:   load_val = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_val = {16'h0000, sel_half};
            OP_LB:   load_val = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_val = {24'h000000, sel_byte};
            default: load_val = bus.mem_dout;
        endcase

        merged = bus.mem_dout;
        if (op_q == OP_SB) begin
            case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // Every output is a flop; outputs for a state are decided on the edge
    // that enters it.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_wr_d   = 1'b0;
        mem_din_d  = mem_din_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        exc_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    off_d   = bus.addr[1:0];
                    wdata_d = bus.wdata[15:0];
                    busy_d  = 1'b1;
                    if (misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        exc_d   = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        mem_addr_d = {bus.addr[31:2], 2'b00};
                        if (bus.op == OP_SW) begin
                            mem_wr_d  = 1'b1;
                            mem_din_d = bus.wdata;
                        end
                    end
                end
            end
            ISSUE: begin
                if (op_q == OP_SW) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (op_q == OP_SH || op_q == OP_SB) begin
                        state_d   = WRITE;
                        mem_wr_d  = 1'b1;
                        mem_din_d = merged;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        rdata_d = load_val;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WRITE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 3'd0;
            off_q      <= 2'd0;
            wdata_q    <= 16'h0000;
            cnt_q      <= 3'd0;
            mem_addr_q <= 32'h0;
            mem_wr_q   <= 1'b0;
            mem_din_q  <= 32'h0;
            rdata_q    <= 32'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_wr_q   <= mem_wr_d;
            mem_din_q  <= mem_din_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            exc_q      <= exc_d;
        end
    end

    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wr       = mem_wr_q;
    assign bus.mem_din      = mem_din_q;
    assign bus.rdata        = rdata_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.misalign_exc = exc_q;

endmodule
